tlu_serial_transmitter_fsm: RTL and testbench

TLU_SERIAL_TRANSMITTER_FSM -- requirements
Module: tlu_serial_transmitter_fsm

---
 rtl/tlu_serial_transmitter_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_tlu_serial_transmitter_fsm.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_serial_transmitter_fsm.sv
// -----------------------------------------------------------------------------
// tlu_serial_transmitter_fsm
//
// Trigger-logic-unit side of a TLU handshake. For each trigger request the
// block raises TLU_TRIGGER until the DUT answers with TLU_BUSY. It then
// shifts the current trigger number out on TLU_TRIGGER, one bit per rising
// edge of the DUT-driven TLU_CLOCK. The DUT ends the transaction by dropping
// TLU_BUSY, which increments the trigger number. An optional cycle timeout
// aborts a handshake that stalls.
//
// Ports
//   CLK                  system clock
//   RESET                asynchronous active-high reset
//   TRIGGER_REQUEST      start one transaction (sampled in IDLE)
//   TRIGGER_NUMBER_LOAD  load TRIGGER_NUMBER_INIT into the counter (IDLE only)
//   TRIGGER_NUMBER_INIT  load value
//   TLU_DATA_MSB_FIRST   1 = MSB first, 0 = LSB first (latched at start)
//   HANDSHAKE_TIMEOUT    timeout in CLK cycles, 0 disables it
//   TLU_CLOCK            asynchronous serial clock from the DUT
//   TLU_BUSY             asynchronous busy line from the DUT
//   TLU_TRIGGER          trigger pulse followed by serial data
//   TRIGGER_NUMBER       current trigger-number counter
//   READY                high while idle
//   TRIGGER_DONE         one-cycle pulse on successful completion
//   TIMEOUT_ERROR        one-cycle pulse on handshake timeout
// -----------------------------------------------------------------------------
module tlu_serial_transmitter_fsm #(
  parameter int unsigned TRIGGER_NUMBER_WIDTH = 31
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            TRIGGER_REQUEST,
  input  logic                            TRIGGER_NUMBER_LOAD,
  input  logic [TRIGGER_NUMBER_WIDTH-1:0] TRIGGER_NUMBER_INIT,
  input  logic                            TLU_DATA_MSB_FIRST,
  input  logic [15:0]                     HANDSHAKE_TIMEOUT,
  input  logic                            TLU_CLOCK,
  input  logic                            TLU_BUSY,
  output logic                            TLU_TRIGGER,
  output logic [TRIGGER_NUMBER_WIDTH-1:0] TRIGGER_NUMBER,
  output logic                            READY,
  output logic                            TRIGGER_DONE,
  output logic                            TIMEOUT_ERROR
);

  localparam int unsigned W     = TRIGGER_NUMBER_WIDTH;
  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] BIT_TOTAL = CNT_W'(W);
  localparam logic [CNT_W-1:0] BIT_ONE   = CNT_W'(1);
  localparam logic [W-1:0]     NUM_ONE   = W'(1);

  typedef enum logic [1:0] {
    ST_IDLE              = 2'd0,
    ST_SEND_TRIGGER      = 2'd1,
    ST_SHIFT_DATA        = 2'd2,
    ST_WAIT_BUSY_RELEASE = 2'd3
  } state_t;

  // Synchronizers and edge detector
  logic       tlu_clock_meta_q, tlu_clock_sync_q, tlu_clock_prev_q;
  logic       tlu_busy_meta_q, tlu_busy_sync_q;
  logic [1:0] sync_fill_q;

  // FSM and datapath state
  state_t             state_q, state_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [15:0]        timeout_cnt_q, timeout_cnt_d;
  logic               msb_first_q, msb_first_d;
  logic               trigger_q, trigger_d;
  logic [W-1:0]       trig_num_q, trig_num_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;

  // Derived combinational signals
  logic        tlu_clock_rise_s;
  logic        sync_ready_s;
  logic [16:0] timeout_next_s;
  logic        timeout_hit_s;
  logic [15:0] timeout_cnt_inc_s;

  // Two-stage synchronizers plus the extra stage used for rising-edge detection.
  // sync_fill_q marks when the busy synchronizer holds real samples again after
  // reset; until then a cleared stage would falsely read "not busy".
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tlu_clock_meta_q <= 1'b0;
      tlu_clock_sync_q <= 1'b0;
      tlu_clock_prev_q <= 1'b0;
      tlu_busy_meta_q  <= 1'b0;
      tlu_busy_sync_q  <= 1'b0;
      sync_fill_q      <= 2'b00;
    end else begin
      tlu_clock_meta_q <= TLU_CLOCK;
      tlu_clock_sync_q <= tlu_clock_meta_q;
      tlu_clock_prev_q <= tlu_clock_sync_q;
      tlu_busy_meta_q  <= TLU_BUSY;
      tlu_busy_sync_q  <= tlu_busy_meta_q;
      sync_fill_q      <= {sync_fill_q[0], 1'b1};
    end
  end

  assign tlu_clock_rise_s = tlu_clock_sync_q & ~tlu_clock_prev_q;
  assign sync_ready_s     = sync_fill_q[1];

  // Timeout fires on the edge where the count of cycles spent in the state
  // reaches HANDSHAKE_TIMEOUT; the counter saturates so a disabled timeout
  // can never wrap into a false match.
  assign timeout_next_s    = {1'b0, timeout_cnt_q} + 17'd1;
  assign timeout_hit_s     = (HANDSHAKE_TIMEOUT != 16'd0) &&
                             (timeout_next_s == {1'b0, HANDSHAKE_TIMEOUT});
  assign timeout_cnt_inc_s = (timeout_cnt_q == 16'hFFFF) ? timeout_cnt_q
                                                         : timeout_next_s[15:0];

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    msb_first_d   = msb_first_q;
    trigger_d     = trigger_q;
    trig_num_d    = trig_num_q;
    timeout_cnt_d = 16'd0;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        trigger_d = 1'b0;
        if (TRIGGER_NUMBER_LOAD) begin
          trig_num_d = TRIGGER_NUMBER_INIT;
        end else if (TRIGGER_REQUEST && sync_ready_s && !tlu_busy_sync_q) begin
          shift_d     = trig_num_q;
          bit_cnt_d   = '0;
          msb_first_d = TLU_DATA_MSB_FIRST;
          trigger_d   = 1'b1;
          state_d     = ST_SEND_TRIGGER;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND_TRIGGER: begin
        timeout_cnt_d = timeout_cnt_inc_s;
        if (tlu_busy_sync_q) begin
          trigger_d     = 1'b0;
          timeout_cnt_d = 16'd0;
          state_d       = ST_SHIFT_DATA;
        end else if (timeout_hit_s) begin
          trigger_d     = 1'b0;
          timeout_err_d = 1'b1;
          timeout_cnt_d = 16'd0;
          state_d       = ST_WAIT_BUSY_RELEASE;
        end else begin
          trigger_d = 1'b1;
        end
      end

      ST_SHIFT_DATA: begin
        timeout_cnt_d = timeout_cnt_inc_s;
        // Busy release wins over a simultaneous clock edge: no further bit.
        if (!tlu_busy_sync_q) begin
          trigger_d     = 1'b0;
          trig_num_d    = trig_num_q + NUM_ONE;
          done_d        = 1'b1;
          timeout_cnt_d = 16'd0;
          state_d       = ST_IDLE;
        end else if (timeout_hit_s) begin
          trigger_d     = 1'b0;
          timeout_err_d = 1'b1;
          timeout_cnt_d = 16'd0;
          state_d       = ST_WAIT_BUSY_RELEASE;
        end else if (tlu_clock_rise_s) begin
          if (bit_cnt_q < BIT_TOTAL) begin
            if (msb_first_q) begin
              trigger_d = shift_q[W-1];
              shift_d   = {shift_q[W-2:0], 1'b0};
            end else begin
              trigger_d = shift_q[0];
              shift_d   = {1'b0, shift_q[W-1:1]};
            end
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end else begin
            trigger_d = 1'b0;
          end
        end else begin
          trigger_d = trigger_q;
        end
      end

      ST_WAIT_BUSY_RELEASE: begin
        trigger_d = 1'b0;
        if (!tlu_busy_sync_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_BUSY_RELEASE;
        end
      end

      default: begin
        trigger_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and registered-output flops
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      timeout_cnt_q <= 16'd0;
      msb_first_q   <= 1'b0;
      trigger_q     <= 1'b0;
      trig_num_q    <= '0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      msb_first_q   <= msb_first_d;
      trigger_q     <= trigger_d;
      trig_num_q    <= trig_num_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign TLU_TRIGGER    = trigger_q;
  assign TRIGGER_NUMBER = trig_num_q;
  assign READY          = ready_q;
  assign TRIGGER_DONE   = done_q;
  assign TIMEOUT_ERROR  = timeout_err_q;

endmodule

// File: tb/tb_tlu_serial_transmitter_fsm.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for tlu_serial_transmitter_fsm. The bench plays
// the DUT side of the TLU handshake (TLU_BUSY / TLU_CLOCK) and checks the
// serial stream and status outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_tlu_serial_transmitter_fsm;

  localparam int W = 31;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          TRIGGER_REQUEST;
  logic          TRIGGER_NUMBER_LOAD;
  logic [W-1:0]  TRIGGER_NUMBER_INIT;
  logic          TLU_DATA_MSB_FIRST;
  logic [15:0]   HANDSHAKE_TIMEOUT;
  logic          TLU_CLOCK;
  logic          TLU_BUSY;
  logic          TLU_TRIGGER;
  logic [W-1:0]  TRIGGER_NUMBER;
  logic          READY;
  logic          TRIGGER_DONE;
  logic          TIMEOUT_ERROR;

  int errors = 0;
  int checks = 0;

  tlu_serial_transmitter_fsm #(.TRIGGER_NUMBER_WIDTH(W)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .TRIGGER_REQUEST     (TRIGGER_REQUEST),
    .TRIGGER_NUMBER_LOAD (TRIGGER_NUMBER_LOAD),
    .TRIGGER_NUMBER_INIT (TRIGGER_NUMBER_INIT),
    .TLU_DATA_MSB_FIRST  (TLU_DATA_MSB_FIRST),
    .HANDSHAKE_TIMEOUT   (HANDSHAKE_TIMEOUT),
    .TLU_CLOCK           (TLU_CLOCK),
    .TLU_BUSY            (TLU_BUSY),
    .TLU_TRIGGER         (TLU_TRIGGER),
    .TRIGGER_NUMBER      (TRIGGER_NUMBER),
    .READY               (READY),
    .TRIGGER_DONE        (TRIGGER_DONE),
    .TIMEOUT_ERROR       (TIMEOUT_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic load_number(input logic [W-1:0] value);
    TRIGGER_NUMBER_INIT = value;
    TRIGGER_NUMBER_LOAD = 1'b1;
    ticks(1);
    TRIGGER_NUMBER_LOAD = 1'b0;
    checks++;
    if (TRIGGER_NUMBER !== value) begin
      errors++;
      $display("FAIL load_number: got %h expected %h", TRIGGER_NUMBER, value);
    end
  endtask

  // One-cycle request; the trigger must be high and READY low right after.
  task automatic start_transaction();
    TRIGGER_REQUEST = 1'b1;
    ticks(1);
    TRIGGER_REQUEST = 1'b0;
    checks++;
    if (TLU_TRIGGER !== 1'b1 || READY !== 1'b0) begin
      errors++;
      $display("FAIL start: trigger=%b ready=%b expected trigger=1 ready=0", TLU_TRIGGER, READY);
    end
  endtask

  // Raise busy; trigger must drop on the 3rd edge (2 sync stages + register).
  task automatic raise_busy();
    int n;
    TLU_BUSY = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      ticks(1);
      if (TLU_TRIGGER === 1'b0) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL busy_to_trigger_low: took %0d cycles expected 3", n);
    end
  endtask

  // One TLU_CLOCK pulse: high for 3 edges (the bit appears on the 3rd), low for 2.
  task automatic pulse_clock(output logic b, output int hold_err);
    hold_err = 0;
    TLU_CLOCK = 1'b1;
    ticks(3);
    b = TLU_TRIGGER;
    TLU_CLOCK = 1'b0;
    ticks(2);
    if (TLU_TRIGGER !== b) hold_err = 1;
  endtask

  // got[W-1-i] holds the i-th transmitted bit, so MSB-first data reads as-is.
  task automatic shift_bits(input int nbits, output logic [W-1:0] got, output int hold_errs);
    logic b;
    int   h;
    got = '0;
    hold_errs = 0;
    for (int i = 0; i < nbits; i++) begin
      pulse_clock(b, h);
      got[W-1-i] = b;
      hold_errs += h;
    end
  endtask

  // Drop busy; DONE must pulse exactly once, on the 3rd edge.
  task automatic finish_busy();
    int cnt;
    int first;
    TLU_BUSY = 1'b0;
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      ticks(1);
      if (TRIGGER_DONE === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    checks++;
    if (cnt != 1 || first != 3) begin
      errors++;
      $display("FAIL done_pulse: count=%0d first_cycle=%0d expected count=1 first_cycle=3", cnt, first);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ticks(2);
    checks++;
    if (TLU_TRIGGER !== 1'b0 || READY !== 1'b1 || TRIGGER_NUMBER !== 31'h0 ||
        TRIGGER_DONE !== 1'b0 || TIMEOUT_ERROR !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: trig=%b ready=%b num=%h done=%b err=%b expected 0 1 0 0 0",
               TLU_TRIGGER, READY, TRIGGER_NUMBER, TRIGGER_DONE, TIMEOUT_ERROR);
    end
    RESET = 1'b0;
    ticks(3);
  endtask

  task automatic test_load_and_request();
    int trig_seen;
    TRIGGER_NUMBER_INIT = 31'h5;
    TRIGGER_NUMBER_LOAD = 1'b1;
    TRIGGER_REQUEST = 1'b1;
    ticks(1);
    TRIGGER_NUMBER_LOAD = 1'b0;
    TRIGGER_REQUEST = 1'b0;
    checks++;
    if (TRIGGER_NUMBER !== 31'h5) begin
      errors++;
      $display("FAIL load_with_request_number: got %h expected %h", TRIGGER_NUMBER, 31'h5);
    end
    trig_seen = 0;
    if (TLU_TRIGGER !== 1'b0) trig_seen = 1;
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      if (TLU_TRIGGER !== 1'b0) trig_seen = 1;
    end
    checks++;
    if (trig_seen != 0 || READY !== 1'b1) begin
      errors++;
      $display("FAIL load_with_request_ignored: trigger_seen=%0d ready=%b expected 0 1", trig_seen, READY);
    end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] got;
    int           holds;
    logic         b;
    int           h;
    TLU_DATA_MSB_FIRST = 1'b1;
    start_transaction();
    // Changes after start must not affect this transaction.
    TLU_DATA_MSB_FIRST = 1'b0;
    TRIGGER_NUMBER_INIT = 31'h7FFF_FFFF;
    ticks(5);
    checks++;
    if (TLU_TRIGGER !== 1'b1) begin
      errors++;
      $display("FAIL trigger_held_until_busy: got %b expected 1", TLU_TRIGGER);
    end
    raise_busy();
    shift_bits(W, got, holds);
    checks++;
    if (got !== 31'h0000_0005) begin
      errors++;
      $display("FAIL msb_first_data: got %h expected %h", got, 31'h0000_0005);
    end
    checks++;
    if (holds != 0) begin
      errors++;
      $display("FAIL data_hold: %0d bits changed between edges, expected 0", holds);
    end
    // An edge beyond the last bit must drive 0.
    pulse_clock(b, h);
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL extra_edge_zero: got %b expected 0", b);
    end
    finish_busy();
    checks++;
    if (TRIGGER_NUMBER !== 31'h6 || READY !== 1'b1) begin
      errors++;
      $display("FAIL msb_first_increment: num=%h ready=%b expected %h 1", TRIGGER_NUMBER, READY, 31'h6);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] got;
    int           holds;
    load_number(31'h5);
    TLU_DATA_MSB_FIRST = 1'b0;
    start_transaction();
    raise_busy();
    shift_bits(W, got, holds);
    checks++;
    if (got !== 31'h5000_0000) begin
      errors++;
      $display("FAIL lsb_first_data: got %h expected %h", got, 31'h5000_0000);
    end
    finish_busy();
    checks++;
    if (TRIGGER_NUMBER !== 31'h6) begin
      errors++;
      $display("FAIL lsb_first_increment: got %h expected %h", TRIGGER_NUMBER, 31'h6);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] got;
    int           holds;
    load_number(31'h7FFF_FFFF);
    TLU_DATA_MSB_FIRST = 1'b1;
    start_transaction();
    raise_busy();
    shift_bits(W, got, holds);
    checks++;
    if (got !== 31'h7FFF_FFFF) begin
      errors++;
      $display("FAIL wrap_data: got %h expected %h", got, 31'h7FFF_FFFF);
    end
    finish_busy();
    checks++;
    if (TRIGGER_NUMBER !== 31'h0) begin
      errors++;
      $display("FAIL wrap_number: got %h expected %h", TRIGGER_NUMBER, 31'h0);
    end
  endtask

  task automatic test_early_done();
    logic [W-1:0] got;
    logic [9:0]   first10;
    int           holds;
    int           cnt;
    int           late_trig;
    load_number(31'h7FE0_0000);
    TLU_DATA_MSB_FIRST = 1'b1;
    start_transaction();
    raise_busy();
    shift_bits(10, got, holds);
    first10 = got[W-1:W-10];
    checks++;
    if (first10 !== 10'h3FF) begin
      errors++;
      $display("FAIL early_done_bits: got %h expected %h", first10, 10'h3FF);
    end
    // Busy drop and clock edge reach the FSM in the same cycle.
    TLU_BUSY = 1'b0;
    TLU_CLOCK = 1'b1;
    cnt = 0;
    late_trig = 0;
    for (int i = 1; i <= 8; i++) begin
      ticks(1);
      if (TRIGGER_DONE === 1'b1) cnt++;
      if (i >= 3 && TLU_TRIGGER !== 1'b0) late_trig++;
    end
    TLU_CLOCK = 1'b0;
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL early_done_pulse: count=%0d expected 1", cnt);
    end
    checks++;
    if (late_trig != 0) begin
      errors++;
      $display("FAIL early_done_no_more_bits: trigger high %0d cycles expected 0", late_trig);
    end
    checks++;
    if (TRIGGER_NUMBER !== 31'h7FE0_0001) begin
      errors++;
      $display("FAIL early_done_number: got %h expected %h", TRIGGER_NUMBER, 31'h7FE0_0001);
    end
    ticks(3);
  endtask

  task automatic test_timeout();
    int n;
    HANDSHAKE_TIMEOUT = 16'd100;
    start_transaction();
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      ticks(1);
      if (TIMEOUT_ERROR === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 100 || TLU_TRIGGER !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cycle: error at cycle %0d trigger=%b expected cycle 100 trigger 0", n, TLU_TRIGGER);
    end
    ticks(1);
    checks++;
    if (TIMEOUT_ERROR !== 1'b0 || READY !== 1'b1 || TRIGGER_NUMBER !== 31'h7FE0_0001) begin
      errors++;
      $display("FAIL timeout_after: err=%b ready=%b num=%h expected 0 1 %h",
               TIMEOUT_ERROR, READY, TRIGGER_NUMBER, 31'h7FE0_0001);
    end
    HANDSHAKE_TIMEOUT = 16'd0;
    ticks(2);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got;
    int           holds;
    int           bad;
    int           n;
    load_number(31'h7FFF_FFFF);
    TLU_DATA_MSB_FIRST = 1'b1;
    start_transaction();
    raise_busy();
    shift_bits(15, got, holds);
    checks++;
    if (TLU_TRIGGER !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: trigger=%b expected 1", TLU_TRIGGER);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (TLU_TRIGGER !== 1'b0 || TRIGGER_NUMBER !== 31'h0 || TRIGGER_DONE !== 1'b0 || READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: trig=%b num=%h done=%b ready=%b expected 0 0 0 1",
               TLU_TRIGGER, TRIGGER_NUMBER, TRIGGER_DONE, READY);
    end
    ticks(1);
    RESET = 1'b0;
    // Busy still high: the request must be held off.
    TRIGGER_REQUEST = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      ticks(1);
      if (TLU_TRIGGER !== 1'b0 || TRIGGER_DONE !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_blocked: bad_cycles=%0d ready=%b expected 0 1", bad, READY);
    end
    TLU_BUSY = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      ticks(1);
      if (TLU_TRIGGER === 1'b1) begin
        n = i;
        break;
      end
    end
    TRIGGER_REQUEST = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL reset_mid_accept: trigger after %0d cycles expected 3", n);
    end
    raise_busy();
    finish_busy();
    checks++;
    if (TRIGGER_NUMBER !== 31'h1) begin
      errors++;
      $display("FAIL reset_mid_number: got %h expected %h", TRIGGER_NUMBER, 31'h1);
    end
  endtask

  initial begin
    RESET               = 1'b1;
    TRIGGER_REQUEST     = 1'b0;
    TRIGGER_NUMBER_LOAD = 1'b0;
    TRIGGER_NUMBER_INIT = '0;
    TLU_DATA_MSB_FIRST  = 1'b1;
    HANDSHAKE_TIMEOUT   = 16'd0;
    TLU_CLOCK           = 1'b0;
    TLU_BUSY            = 1'b0;

    test_reset();
    test_load_and_request();
    test_msb_first();
    test_lsb_first();
    test_wrap();
    test_early_done();
    test_timeout();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
